// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter FSM states, frame length and the odd-parity helper.
// Also used by the host-side receiver and its bench.
package ps2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2,
      GAP  = 2'd3
   } ps2_state_t;

   localparam int PS2_FRAME_BITS = 11;

   // Odd parity: the data bits plus the parity bit always hold an odd number of ones.
   function automatic logic ps2_odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO. The head is read combinationally so the transmitter can
// load a frame without popping; the entry is popped only once its frame completes.
module ps2_tx_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           i_push,
   input  logic [WIDTH-1:0]               i_data,
   input  logic                           i_pop,
   output logic [WIDTH-1:0]               o_head,
   output logic [$clog2(DEPTH+1)-1:0]     o_count,
   output logic                           o_ready
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign o_ready = (r_count < CW'(DEPTH));
   assign w_push  = i_push & o_ready;
   assign w_pop   = i_pop & (r_count != '0);
   assign o_head  = r_mem[r_rd_ptr];
   assign o_count = r_count;

   // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_push && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_push && w_pop) r_count <= r_count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: buffers scan-code bytes and serialises each as an
// 11-bit frame, generating ps2_clk itself. Host inhibit aborts an unfinished frame.
module ps2_device_tx
   import ps2_pkg::*;
#(
   parameter int CLK_DIV    = 50,
   parameter int GAP_DIV    = 100,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                                clk,
   input  logic                                resetn,
   input  logic [7:0]                          in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic                                inhibit,
   output logic                                ps2_clk,
   output logic                                ps2_data,
   output logic                                busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
   localparam int DIV_MAX = (CLK_DIV > GAP_DIV) ? CLK_DIV : GAP_DIV;
   localparam int DW      = $clog2(DIV_MAX);
   localparam logic [DW-1:0] CLK_RELOAD = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] GAP_RELOAD = DW'(GAP_DIV - 1);
   localparam logic [3:0]    LAST_BIT   = 4'(PS2_FRAME_BITS - 1);

   ps2_state_t    r_state, w_state_next;
   logic [DW-1:0] r_div, w_div_next;
   logic [3:0]    r_bit_cnt, w_bit_cnt_next;
   logic [10:0]   r_shift, w_shift_next;
   logic          r_ps2_clk, r_ps2_data, r_busy;
   logic          w_pop;
   logic          w_abort;
   logic [7:0]    w_head;

   ps2_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (in_valid),
      .i_data  (in_data),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (fifo_count),
      .o_ready (in_ready)
   );

   // Once the stop bit is on the wire the frame is allowed to finish.
   assign w_abort = inhibit && (r_bit_cnt != LAST_BIT);

   always_comb begin
      w_state_next   = r_state;
      w_div_next     = r_div;
      w_bit_cnt_next = r_bit_cnt;
      w_shift_next   = r_shift;
      w_pop          = 1'b0;
      case (r_state)
         IDLE: begin
            if (fifo_count != '0 && !inhibit) begin
               w_state_next   = HIGH;
               w_div_next     = CLK_RELOAD;
               w_bit_cnt_next = 4'd0;
               w_shift_next   = {1'b1, ps2_odd_parity(w_head), w_head, 1'b0};
            end
         end
         HIGH: begin
            if (w_abort) begin
               w_state_next = GAP;
               w_div_next   = GAP_RELOAD;
            end else if (r_div == '0) begin
               w_state_next = LOW;
               w_div_next   = CLK_RELOAD;
            end else begin
               w_div_next = r_div - 1'b1;
            end
         end
         LOW: begin
            if (w_abort) begin
               w_state_next = GAP;
               w_div_next   = GAP_RELOAD;
            end else if (r_div == '0) begin
               if (r_bit_cnt == LAST_BIT) begin
                  w_pop        = 1'b1;
                  w_state_next = GAP;
                  w_div_next   = GAP_RELOAD;
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 4'd1;
                  w_shift_next   = {1'b1, r_shift[10:1]};
                  w_state_next   = HIGH;
                  w_div_next     = CLK_RELOAD;
               end
            end else begin
               w_div_next = r_div - 1'b1;
            end
         end
         GAP: begin
            if (r_div == '0) w_state_next = IDLE;
            else             w_div_next   = r_div - 1'b1;
         end
         default: w_state_next = IDLE;
      endcase
   end

   // Line outputs are registered from the next state so they change with it, glitch-free.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state    <= IDLE;
         r_div      <= '0;
         r_bit_cnt  <= 4'd0;
         r_shift    <= '1;
         r_ps2_clk  <= 1'b1;
         r_ps2_data <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_div      <= w_div_next;
         r_bit_cnt  <= w_bit_cnt_next;
         r_shift    <= w_shift_next;
         r_ps2_clk  <= (w_state_next != LOW);
         r_ps2_data <= (w_state_next == HIGH || w_state_next == LOW) ? w_shift_next[0] : 1'b1;
         r_busy     <= (w_state_next != IDLE);
      end
   end

   assign ps2_clk  = r_ps2_clk;
   assign ps2_data = r_ps2_data;
   assign busy     = r_busy;

endmodule

// File: tb/tb_ps2_device_tx.sv
// Directed bench for ps2_device_tx (CLK_DIV=4, GAP_DIV=8) with a host-side frame monitor.
module tb_ps2_device_tx;
   localparam int CLK_DIV = 4;
   localparam int GAP_DIV = 8;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic       inhibit = 1'b0;
   logic       ps2_clk;
   logic       ps2_data;
   logic       busy;
   logic [3:0] fifo_count;

   int n_checks = 0;
   int n_pass   = 0;

   ps2_device_tx #(.CLK_DIV(CLK_DIV), .GAP_DIV(GAP_DIV), .FIFO_DEPTH(8)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .inhibit    (inhibit),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   // Host monitor: samples data on ps2_clk falling edges, drops partial frames after a long idle.
   logic [10:0] rx_sh = '0;
   int          rx_n = 0;
   int          hi_cnt = 0;
   logic        prev_clk = 1'b1;
   int          fall_cnt = 0;
   int          rx_err = 0;
   logic [7:0]  rx_q[$];
   logic [10:0] frame_q[$];

   always @(negedge clk) begin
      if (prev_clk && !ps2_clk) begin
         rx_sh = {ps2_data, rx_sh[10:1]};
         rx_n = rx_n + 1;
         fall_cnt = fall_cnt + 1;
         if (rx_n == 11) begin
            rx_n = 0;
            frame_q.push_back(rx_sh);
            if (rx_sh[0] == 1'b0 && rx_sh[10] == 1'b1 && rx_sh[9] == ~^rx_sh[8:1])
               rx_q.push_back(rx_sh[8:1]);
            else
               rx_err = rx_err + 1;
         end
      end
      if (ps2_clk) hi_cnt = hi_cnt + 1;
      else         hi_cnt = 0;
      if (hi_cnt > 2 * CLK_DIV) rx_n = 0;
      prev_clk = ps2_clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_byte(input logic [7:0] b);
      int wt;
      wt = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && wt < 2000) begin
         tick();
         wt++;
      end
      tick();
      in_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int wt;
      wt = 0;
      while ((busy || fifo_count != 4'd0) && wt < 3000) begin
         tick();
         wt++;
      end
      check(tag, 32'(wt < 3000), 32'd1);
   endtask

   task automatic rx_expect(input string tag, input logic [7:0] exp);
      logic [31:0] got;
      got = (rx_q.size() > 0) ? 32'(rx_q.pop_front()) : 32'hFFFF_FFFF;
      check(tag, got, 32'(exp));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int f0;
      int e0;
      logic [7:0] bytes9 [9];
      bytes9 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h55};

      // Reset state
      tick(3);
      check("rst_ps2_clk", 32'(ps2_clk), 32'd1);
      check("rst_ps2_data", 32'(ps2_data), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      resetn = 1'b1;
      tick(20);

      // 1: single byte 0x1C, latency, frame length, gap
      f0 = fall_cnt; e0 = rx_err; rx_q.delete(); frame_q.delete();
      in_data = 8'h1C; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_count_push", 32'(fifo_count), 32'd1);
      check("t1_data_before_start", 32'(ps2_data), 32'd1);
      tick();
      check("t1_start_bit", 32'(ps2_data), 32'd0);
      check("t1_busy", 32'(busy), 32'd1);
      n = 0;
      while (fifo_count != 4'd0 && n < 500) begin tick(); n++; end
      check("t1_frame_cycles", 32'(n), 32'd88);
      check("t1_falls", 32'(fall_cnt - f0), 32'd11);
      n = 0;
      while (busy && n < 500) begin tick(); n++; end
      check("t1_gap_cycles", 32'(n), 32'd8);
      check("t1_frame_bits", (frame_q.size() > 0) ? 32'(frame_q.pop_front()) : 32'hFFFF_FFFF, 32'h438);
      rx_expect("t1_rx", 8'h1C);
      check("t1_rx_err", 32'(rx_err - e0), 32'd0);

      // 2: parity corner bytes
      e0 = rx_err; rx_q.delete(); frame_q.delete();
      push_byte(8'h00);
      push_byte(8'hFF);
      wait_idle("t2_idle");
      check("t2_frame_00", (frame_q.size() > 0) ? 32'(frame_q.pop_front()) : 32'hFFFF_FFFF, 32'h600);
      check("t2_frame_FF", (frame_q.size() > 0) ? 32'(frame_q.pop_front()) : 32'hFFFF_FFFF, 32'h7FE);
      rx_expect("t2_rx0", 8'h00);
      rx_expect("t2_rx1", 8'hFF);
      check("t2_rx_err", 32'(rx_err - e0), 32'd0);

      // 3: nine back-to-back pushes into an 8-deep FIFO
      e0 = rx_err; rx_q.delete(); f0 = fall_cnt;
      for (int i = 0; i < 9; i++) begin
         in_data  = bytes9[i];
         in_valid = 1'b1;
         if (i == 8) begin
            check("t3_full_count", 32'(fifo_count), 32'd8);
            check("t3_full_ready", 32'(in_ready), 32'd0);
         end
         n = 0;
         while (!in_ready && n < 2000) begin tick(); n++; end
         if (i == 8) begin
            check("t3_ready_after_pop", 32'(fifo_count), 32'd7);
            check("t3_falls_at_pop", 32'(fall_cnt - f0), 32'd11);
         end
         tick();
      end
      in_valid = 1'b0;
      check("t3_count_refill", 32'(fifo_count), 32'd8);
      wait_idle("t3_idle");
      for (int i = 0; i < 9; i++) rx_expect($sformatf("t3_rx%0d", i), bytes9[i]);
      check("t3_rx_err", 32'(rx_err - e0), 32'd0);

      // 4: inhibit during bit 4 LOW aborts, byte resent after release
      e0 = rx_err; rx_q.delete(); f0 = fall_cnt;
      push_byte(8'hA5);
      n = 0;
      while (fall_cnt - f0 < 5 && n < 500) begin tick(); n++; end
      check("t4_in_low", 32'(ps2_clk), 32'd0);
      inhibit = 1'b1;
      tick();
      check("t4_abort_clk", 32'(ps2_clk), 32'd1);
      check("t4_abort_data", 32'(ps2_data), 32'd1);
      check("t4_abort_count", 32'(fifo_count), 32'd1);
      f0 = fall_cnt;
      tick(30);
      check("t4_held_falls", 32'(fall_cnt - f0), 32'd0);
      check("t4_held_busy", 32'(busy), 32'd0);
      check("t4_held_count", 32'(fifo_count), 32'd1);
      inhibit = 1'b0;
      wait_idle("t4_idle");
      check("t4_resend_falls", 32'(fall_cnt - f0), 32'd11);
      rx_expect("t4_rx", 8'hA5);
      check("t4_rx_extra", 32'(rx_q.size()), 32'd0);
      check("t4_rx_err", 32'(rx_err - e0), 32'd0);

      // 5: inhibit held from reset blocks the frame until release
      e0 = rx_err; rx_q.delete();
      resetn = 1'b0; inhibit = 1'b1;
      tick(2);
      resetn = 1'b1;
      tick();
      f0 = fall_cnt;
      push_byte(8'hF0);
      tick(60);
      check("t5_no_falls", 32'(fall_cnt - f0), 32'd0);
      check("t5_not_busy", 32'(busy), 32'd0);
      check("t5_count", 32'(fifo_count), 32'd1);
      inhibit = 1'b0;
      wait_idle("t5_idle");
      check("t5_falls", 32'(fall_cnt - f0), 32'd11);
      rx_expect("t5_rx", 8'hF0);
      check("t5_rx_err", 32'(rx_err - e0), 32'd0);

      // 6: reset during bit 6
      e0 = rx_err; rx_q.delete(); f0 = fall_cnt;
      push_byte(8'h3C);
      n = 0;
      while (fall_cnt - f0 < 7 && n < 500) begin tick(); n++; end
      resetn = 1'b0;
      tick();
      check("t6_clk", 32'(ps2_clk), 32'd1);
      check("t6_data", 32'(ps2_data), 32'd1);
      check("t6_count", 32'(fifo_count), 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      check("t6_busy", 32'(busy), 32'd0);
      resetn = 1'b1;
      tick(40);
      check("t6_no_frame", 32'(rx_q.size()), 32'd0);
      check("t6_rx_err", 32'(rx_err - e0), 32'd0);
      check("t6_still_idle", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
